fp_issue_ctrl: RTL and testbench

- Core-side counterpart of the FPU wrapper handshake.
- Accepts decoded FP instructions from the core pipeline and drives the FPU input handshake (valid/ready).
- Tracks in-flight destination info in an ordered tag FIFO, consumes FPU results via the output handshake, and routes writeback to the FP or integer register file.
- Accumulates exception flags and handles flush by draining the FPU.

---
 rtl/fp_issue_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_fp_issue_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: core-side issue/writeback controller for an FPU with
// valid/ready handshakes. Issues decoded FP instructions, tracks destination
// info of in-flight ops in an ordered tag FIFO, routes results to the FP or
// integer register file, accumulates sticky exception flags and drains the
// FPU on a pipeline flush.
// Optional feature: define FP_SCOREBOARD_EN to enable a 32-entry busy vector
// for FP destinations that blocks issue on RAW/WAW hazards.
module fp_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int FLAGW = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [4:0]       dec_rd_i,
    input  logic             dec_wb_int_i,
    input  logic [14:0]      dec_rs_i,
    output logic             fpu_valid_o,
    output logic [31:0]      fpu_instr_o,
    input  logic             fpu_ready_i,
    output logic             fpu_flush_o,
    input  logic             fpu_busy_i,
    input  logic             fpu_out_valid_i,
    output logic             fpu_out_ready_o,
    input  logic [31:0]      fpu_result_i,
    input  logic [FLAGW-1:0] fpu_status_i,
    input  logic             irf_gnt_i,
    output logic             frf_we_o,
    output logic [4:0]       frf_waddr_o,
    output logic [31:0]      frf_wdata_o,
    output logic             irf_we_o,
    output logic [4:0]       irf_waddr_o,
    output logic [31:0]      irf_wdata_o,
    output logic [FLAGW-1:0] fflags_o,
    input  logic             fflags_clr_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Tag FIFO: each entry is {rd, wb_int}
    logic [5:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, empty;
    logic [4:0]       head_rd;
    logic             head_wb_int;

    logic             run;
    logic             hazard;
    logic             push, pop;

    // Registered writeback stage
    logic             wb_vld;
    logic             wb_int;
    logic [4:0]       wb_addr;
    logic [31:0]      wb_data;

    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign head_rd     = fifo_mem[rd_ptr][5:1];
    assign head_wb_int = fifo_mem[rd_ptr][0];
    assign run         = (state == RUN);

    assign push = instr_ready_o;
    assign pop  = run & fpu_out_valid_i & fpu_out_ready_o & ~empty;

    assign fpu_instr_o = instr_i;
    assign busy_o      = ~empty | ~run;

    assign frf_we_o    = wb_vld & ~wb_int;
    assign irf_we_o    = wb_vld & wb_int;
    assign frf_waddr_o = wb_addr;
    assign irf_waddr_o = wb_addr;
    assign frf_wdata_o = wb_data;
    assign irf_wdata_o = wb_data;

`ifdef FP_SCOREBOARD_EN
    logic [31:0] sb_busy;

    // An op may not issue while any of its sources or its destination is pending
    always_comb begin
        hazard = sb_busy[dec_rs_i[4:0]] | sb_busy[dec_rs_i[9:5]] |
                 sb_busy[dec_rs_i[14:10]] | sb_busy[dec_rd_i];
    end

    // Busy bits: set on FP-destination push, cleared when that op's result pops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb_busy <= '0;
        end else if (state == FLUSH) begin
            sb_busy <= '0;
        end else begin
            if (pop && !head_wb_int) sb_busy[head_rd] <= 1'b0;
            if (push && !dec_wb_int_i) sb_busy[dec_rd_i] <= 1'b1;
        end
    end
`else
    logic unused_rs;
    assign unused_rs = ^dec_rs_i;
    assign hazard    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= RUN;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt       = state;
        fpu_valid_o     = 1'b0;
        instr_ready_o   = 1'b0;
        fpu_out_ready_o = 1'b0;
        fpu_flush_o     = 1'b0;
        case (state)
            RUN: begin
                fpu_valid_o   = instr_valid_i & ~full & ~hazard;
                instr_ready_o = fpu_valid_o & fpu_ready_i;
                // With nothing in flight, any result is swallowed (and flagged as error)
                fpu_out_ready_o = empty ? fpu_out_valid_i : (~head_wb_int | irf_gnt_i);
                if (flush_i) state_nxt = FLUSH;
            end
            FLUSH: begin
                fpu_flush_o     = 1'b1;
                fpu_out_ready_o = 1'b1;
                state_nxt       = flush_i ? FLUSH : DRAIN;
            end
            DRAIN: begin
                fpu_out_ready_o = 1'b1;
                if (flush_i)                              state_nxt = FLUSH;
                else if (!fpu_busy_i && !fpu_out_valid_i) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Tag FIFO pointers and occupancy; emptied at the end of the flush cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (state == FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Tag FIFO storage
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= {dec_rd_i, dec_wb_int_i};
    end

    // Writeback register: one-cycle pulse after the result handshake,
    // dropped if the following cycle is the flush cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_vld  <= 1'b0;
            wb_int  <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_vld <= pop & ~flush_i;
            if (pop) begin
                wb_int  <= head_wb_int;
                wb_addr <= head_rd;
                wb_data <= fpu_result_i;
            end
        end
    end

    // Sticky exception flags; a clear wins over that cycle's accumulation
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)             fflags_o <= '0;
        else if (fflags_clr_i) fflags_o <= '0;
        else if (pop)          fflags_o <= fflags_o | fpu_status_i;
    end

    // Sticky error: a result arrived while nothing was in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                err_o <= 1'b0;
        else if (run && fpu_out_valid_i && empty) err_o <= 1'b1;
    end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed self-checking bench for fp_issue_ctrl (default build; the
// scoreboard scenario runs only when FP_SCOREBOARD_EN is defined).
module tb_fp_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] instr_i;
    logic [4:0]  dec_rd_i;
    logic        dec_wb_int_i;
    logic [14:0] dec_rs_i;
    logic        fpu_valid_o;
    logic [31:0] fpu_instr_o;
    logic        fpu_ready_i;
    logic        fpu_flush_o;
    logic        fpu_busy_i;
    logic        fpu_out_valid_i;
    logic        fpu_out_ready_o;
    logic [31:0] fpu_result_i;
    logic [4:0]  fpu_status_i;
    logic        irf_gnt_i;
    logic        frf_we_o;
    logic [4:0]  frf_waddr_o;
    logic [31:0] frf_wdata_o;
    logic        irf_we_o;
    logic [4:0]  irf_waddr_o;
    logic [31:0] irf_wdata_o;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i;
    logic        flush_i;
    logic        busy_o;
    logic        err_o;

    int n_cmp = 0;
    int n_err = 0;

    fp_issue_ctrl #(.DEPTH(4), .FLAGW(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_i(instr_i), .dec_rd_i(dec_rd_i), .dec_wb_int_i(dec_wb_int_i),
        .dec_rs_i(dec_rs_i),
        .fpu_valid_o(fpu_valid_o), .fpu_instr_o(fpu_instr_o),
        .fpu_ready_i(fpu_ready_i), .fpu_flush_o(fpu_flush_o),
        .fpu_busy_i(fpu_busy_i), .fpu_out_valid_i(fpu_out_valid_i),
        .fpu_out_ready_o(fpu_out_ready_o), .fpu_result_i(fpu_result_i),
        .fpu_status_i(fpu_status_i), .irf_gnt_i(irf_gnt_i),
        .frf_we_o(frf_we_o), .frf_waddr_o(frf_waddr_o), .frf_wdata_o(frf_wdata_o),
        .irf_we_o(irf_we_o), .irf_waddr_o(irf_waddr_o), .irf_wdata_o(irf_wdata_o),
        .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i), .flush_i(flush_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        instr_valid_i   = 1'b0;
        instr_i         = '0;
        dec_rd_i        = '0;
        dec_wb_int_i    = 1'b0;
        dec_rs_i        = '0;
        fpu_ready_i     = 1'b0;
        fpu_busy_i      = 1'b0;
        fpu_out_valid_i = 1'b0;
        fpu_result_i    = '0;
        fpu_status_i    = '0;
        irf_gnt_i       = 1'b0;
        fflags_clr_i    = 1'b0;
        flush_i         = 1'b0;
    endtask

    // Present one FP instruction for a single cycle and expect it accepted
    task automatic issue(input logic [4:0] rd, input logic wb_int, input string tag);
        instr_valid_i = 1'b1;
        instr_i       = 32'h4000_0000 | 32'(rd);
        dec_rd_i      = rd;
        dec_wb_int_i  = wb_int;
        #2;
        check(tag, instr_ready_o, 1);
        tick();
        instr_valid_i = 1'b0;
        dec_wb_int_i  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #2;
        check("rst_ctl", {24'd0, instr_ready_o, fpu_valid_o, fpu_out_ready_o, fpu_flush_o,
                          frf_we_o, irf_we_o, busy_o, err_o}, 32'd0);
        check("rst_fflags", fflags_o, 0);
        tick();

        // Four back-to-back FP ops fill the FIFO; the fifth stalls
        fpu_ready_i   = 1'b1;
        instr_valid_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            instr_i  = 32'h4000_0000 + 32'(i);
            dec_rd_i = 5'(i);
            #2;
            check("b2b_ready", instr_ready_o, 1);
            check("b2b_instr", fpu_instr_o, 32'h4000_0000 + 32'(i));
            tick();
        end
        instr_i  = 32'h4000_0005;
        dec_rd_i = 5'd5;
        #2;
        check("full_ready", instr_ready_o, 0);
        check("full_valid", fpu_valid_o, 0);
        check("full_busy", busy_o, 1);
        tick();

        // Results return in order; writeback lags each handshake by one cycle
        instr_valid_i   = 1'b0;
        fpu_out_valid_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            fpu_result_i = 32'hA000_0000 + 32'(i);
            #2;
            check("res_out_ready", fpu_out_ready_o, 1);
            if (i > 1) begin
                check("res_frf_we", frf_we_o, 1);
                check("res_frf_waddr", frf_waddr_o, 32'(i - 1));
                check("res_frf_wdata", frf_wdata_o, 32'hA000_0000 + 32'(i - 1));
            end
            tick();
        end
        fpu_out_valid_i = 1'b0;
        #2;
        check("res4_frf_we", frf_we_o, 1);
        check("res4_frf_waddr", frf_waddr_o, 4);
        check("res4_frf_wdata", frf_wdata_o, 32'hA000_0004);
        check("res4_irf_we", irf_we_o, 0);
        tick();
        #2;
        check("res_we_pulse", frf_we_o, 0);
        check("res_idle_busy", busy_o, 0);
        tick();

        // Integer-destination result waits for the integer RF grant
        issue(5'd7, 1'b1, "int_issue");
        fpu_out_valid_i = 1'b1;
        fpu_result_i    = 32'hDEAD_0007;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("int_wait_ready", fpu_out_ready_o, 0);
            tick();
        end
        irf_gnt_i = 1'b1;
        #2;
        check("int_gnt_ready", fpu_out_ready_o, 1);
        tick();
        fpu_out_valid_i = 1'b0;
        irf_gnt_i       = 1'b0;
        #2;
        check("int_irf_we", irf_we_o, 1);
        check("int_irf_waddr", irf_waddr_o, 7);
        check("int_irf_wdata", irf_wdata_o, 32'hDEAD_0007);
        check("int_frf_we", frf_we_o, 0);
        tick();
        #2;
        check("int_we_pulse", irf_we_o, 0);
        tick();

        // Flag accumulation, then clear beating a same-cycle update
        issue(5'd5, 1'b0, "flg_issue5");
        issue(5'd6, 1'b0, "flg_issue6");
        fpu_out_valid_i = 1'b1;
        fpu_status_i    = 5'b00001;
        tick();
        fpu_status_i = 5'b10000;
        #2;
        check("flg_first", fflags_o, 5'b00001);
        tick();
        fpu_out_valid_i = 1'b0;
        fpu_status_i    = '0;
        #2;
        check("flg_accum", fflags_o, 5'b10001);
        tick();
        issue(5'd8, 1'b0, "flg_issue8");
        fpu_out_valid_i = 1'b1;
        fpu_status_i    = 5'b00100;
        fflags_clr_i    = 1'b1;
        tick();
        fpu_out_valid_i = 1'b0;
        fpu_status_i    = '0;
        fflags_clr_i    = 1'b0;
        #2;
        check("flg_clr_prio", fflags_o, 0);
        tick();

        // Flush with three ops in flight; a handshake in the flush-request cycle is dropped
        issue(5'd9, 1'b0, "fl_issue9");
        issue(5'd10, 1'b0, "fl_issue10");
        issue(5'd11, 1'b0, "fl_issue11");
        flush_i         = 1'b1;
        fpu_out_valid_i = 1'b1;
        fpu_result_i    = 32'hBAD0_0009;
        tick();
        flush_i       = 1'b0;
        fpu_busy_i    = 1'b1;
        instr_valid_i = 1'b1;
        instr_i       = 32'h4000_000C;
        dec_rd_i      = 5'd12;
        fpu_status_i  = 5'b11111;
        #2;
        check("fl_flush_pulse", fpu_flush_o, 1);
        check("fl_ready", instr_ready_o, 0);
        check("fl_valid", fpu_valid_o, 0);
        check("fl_out_ready", fpu_out_ready_o, 1);
        check("fl_wb_suppress", frf_we_o, 0);
        check("fl_busy", busy_o, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            #2;
            check("dr_flush_low", fpu_flush_o, 0);
            check("dr_ready", instr_ready_o, 0);
            check("dr_out_ready", fpu_out_ready_o, 1);
            check("dr_no_wr", {31'd0, frf_we_o | irf_we_o}, 0);
            tick();
        end
        fpu_busy_i      = 1'b0;
        fpu_out_valid_i = 1'b0;
        fpu_status_i    = '0;
        #2;
        check("dr_last_ready", instr_ready_o, 0);
        tick();
        #2;
        check("run_ready", instr_ready_o, 1);
        check("run_fflags", fflags_o, 0);
        check("run_err", err_o, 0);
        tick();
        instr_valid_i   = 1'b0;
        fpu_out_valid_i = 1'b1;
        fpu_result_i    = 32'hC000_0012;
        #2;
        check("run_out_ready", fpu_out_ready_o, 1);
        tick();
        fpu_out_valid_i = 1'b0;
        #2;
        check("run_frf_we", frf_we_o, 1);
        check("run_frf_waddr", frf_waddr_o, 12);
        tick();

        // Result with nothing in flight
        fpu_out_valid_i = 1'b1;
        fpu_result_i    = 32'h0000_EEEE;
        #2;
        check("err_out_ready", fpu_out_ready_o, 1);
        check("err_before", err_o, 0);
        tick();
        fpu_out_valid_i = 1'b0;
        #2;
        check("err_set", err_o, 1);
        check("err_no_wr", {31'd0, frf_we_o | irf_we_o}, 0);
        tick();
        #2;
        check("err_sticky", err_o, 1);
        tick();

        // Asynchronous reset mid-operation
        issue(5'd13, 1'b0, "rst_issue");
        #2;
        check("rst_mid_busy_pre", busy_o, 1);
        rst_i = 1'b1;
        #1;
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_err", err_o, 0);
        tick();
        rst_i = 1'b0;
        tick();

`ifdef FP_SCOREBOARD_EN
        // Source hazard on a pending FP destination holds issue until writeback
        issue(5'd3, 1'b0, "sb_issue3");
        instr_valid_i = 1'b1;
        instr_i       = 32'h4000_0004;
        dec_rd_i      = 5'd4;
        dec_rs_i      = {5'd0, 5'd3, 5'd0};
        #2;
        check("sb_hold", fpu_valid_o, 0);
        tick();
        fpu_out_valid_i = 1'b1;
        fpu_result_i    = 32'h0000_0033;
        #2;
        check("sb_hold_hs", fpu_valid_o, 0);
        tick();
        fpu_out_valid_i = 1'b0;
        #2;
        check("sb_release_valid", fpu_valid_o, 1);
        check("sb_release_ready", instr_ready_o, 1);
        tick();
        instr_valid_i   = 1'b0;
        dec_rs_i        = '0;
        fpu_out_valid_i = 1'b1;
        tick();
        fpu_out_valid_i = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
